// File: rtl/if_stage_unit_pkg.sv
// Shared pipeline definitions for the IF and ID stages.
// Holds the NOP encoding and the IF/ID bundle layout.
package if_stage_unit_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] pc_plus4;
        logic [31:0]           instruction;
        logic                  valid;
    } if_id_t;

endpackage

// File: rtl/if_stage_unit_sat_counter.sv
// Unsigned event counter that sticks at all ones.
// Cleared only by the asynchronous reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/if_stage_unit.sv
// Instruction fetch stage with the IF/ID pipeline register.
// Freeze beats branch flush, which beats sequential fetch.
module if_stage_unit
    import if_stage_unit_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] PC_RESET = '0,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_address,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    output logic [ADDR_W-1:0] id_pc_plus4,
    output logic [31:0]       id_instruction,
    output logic              id_valid,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] target;
    logic              flush;

    assign pc_plus4  = pc + ADDR_W'(4);
    assign target    = {branch_address[ADDR_W-1:2], 2'b00};
    assign flush     = !freeze && branch_taken;
    assign imem_addr = pc;

    // A branch seen during a stall is dropped: ID operands are stale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc             <= PC_RESET;
            id_pc_plus4    <= '0;
            id_instruction <= NOP_INSTR;
            id_valid       <= 1'b0;
        end else if (freeze) begin
            pc             <= pc;
        end else if (branch_taken) begin
            pc             <= target;
            id_pc_plus4    <= '0;
            id_instruction <= NOP_INSTR;
            id_valid       <= 1'b0;
        end else begin
            pc             <= pc_plus4;
            id_pc_plus4    <= pc_plus4;
            id_instruction <= imem_data;
            id_valid       <= 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (freeze),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush),
        .count (flush_count)
    );

endmodule

// File: tb/tb_if_stage_unit.sv
// Directed vector bench for if_stage_unit.
// A second narrow-counter instance covers saturation and async reset.
module tb_if_stage_unit;

    logic        clk = 1'b0;
    logic        rst, freeze, branch_taken;
    logic [31:0] branch_address, imem_data;
    logic [31:0] imem_addr, id_pc_plus4, id_instruction;
    logic        id_valid;
    logic [15:0] stall_count, flush_count;

    logic        rst2, freeze2;
    logic [31:0] imem_addr2, id_pc_plus4_2, id_instruction2;
    logic        id_valid2;
    logic [1:0]  stall_count2, flush_count2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    if_stage_unit dut (
        .clk            (clk),
        .rst            (rst),
        .freeze         (freeze),
        .branch_taken   (branch_taken),
        .branch_address (branch_address),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .id_pc_plus4    (id_pc_plus4),
        .id_instruction (id_instruction),
        .id_valid       (id_valid),
        .stall_count    (stall_count),
        .flush_count    (flush_count)
    );

    if_stage_unit #(.PC_RESET(32'h100), .CNT_W(2)) dut2 (
        .clk            (clk),
        .rst            (rst2),
        .freeze         (freeze2),
        .branch_taken   (1'b0),
        .branch_address (32'h0),
        .imem_addr      (imem_addr2),
        .imem_data      (32'h1234_5678),
        .id_pc_plus4    (id_pc_plus4_2),
        .id_instruction (id_instruction2),
        .id_valid       (id_valid2),
        .stall_count    (stall_count2),
        .flush_count    (flush_count2)
    );

    typedef struct {
        logic        frz;
        logic        br;
        logic [31:0] ba;
        logic [31:0] im;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] ins;
        logic        v;
        logic [15:0] sc;
        logic [15:0] fc;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic check_all(input string tag, input logic [31:0] pc,
                             input logic [31:0] pc4, input logic [31:0] ins,
                             input logic v, input logic [15:0] sc,
                             input logic [15:0] fc);
        check({tag, ".pc"}, imem_addr, pc);
        check({tag, ".pc4"}, id_pc_plus4, pc4);
        check({tag, ".instr"}, id_instruction, ins);
        check({tag, ".valid"}, {31'b0, id_valid}, {31'b0, v});
        check({tag, ".stall"}, {16'b0, stall_count}, {16'b0, sc});
        check({tag, ".flush"}, {16'b0, flush_count}, {16'b0, fc});
    endtask

    initial begin
        vecs[0]  = '{0, 0, 32'h0, 32'h2001_0005,
                     32'h4, 32'h4, 32'h2001_0005, 1, 0, 0};
        vecs[1]  = '{0, 0, 32'h0, 32'h2002_0007,
                     32'h8, 32'h8, 32'h2002_0007, 1, 0, 0};
        vecs[2]  = '{1, 0, 32'h0, 32'h0022_1820,
                     32'h8, 32'h8, 32'h2002_0007, 1, 1, 0};
        vecs[3]  = '{1, 0, 32'h0, 32'h0022_1820,
                     32'h8, 32'h8, 32'h2002_0007, 1, 2, 0};
        vecs[4]  = '{0, 0, 32'h0, 32'h0022_1820,
                     32'hC, 32'hC, 32'h0022_1820, 1, 2, 0};
        vecs[5]  = '{0, 0, 32'h0, 32'h8C01_0000,
                     32'h10, 32'h10, 32'h8C01_0000, 1, 2, 0};
        vecs[6]  = '{0, 1, 32'h43, 32'hDEAD_BEEF,
                     32'h40, 32'h0, 32'h0, 0, 2, 1};
        vecs[7]  = '{0, 0, 32'h0, 32'h1111_1111,
                     32'h44, 32'h44, 32'h1111_1111, 1, 2, 1};
        vecs[8]  = '{0, 1, 32'h20, 32'hAAAA_AAAA,
                     32'h20, 32'h0, 32'h0, 0, 2, 2};
        vecs[9]  = '{1, 1, 32'h80, 32'hBBBB_BBBB,
                     32'h20, 32'h0, 32'h0, 0, 3, 2};
        vecs[10] = '{0, 1, 32'hFFFF_FFFE, 32'hCCCC_CCCC,
                     32'hFFFF_FFFC, 32'h0, 32'h0, 0, 3, 3};
        vecs[11] = '{0, 0, 32'hx, 32'h2222_2222,
                     32'h0, 32'h0, 32'h2222_2222, 1, 3, 3};
        vecs[12] = '{0, 0, 32'hx, 32'h3333_3333,
                     32'h4, 32'h4, 32'h3333_3333, 1, 3, 3};

        rst = 1'b1;
        freeze = 1'b0;
        branch_taken = 1'b0;
        branch_address = 32'h0;
        imem_data = 32'h0;
        rst2 = 1'b1;
        freeze2 = 1'b0;

        @(negedge clk);
        check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 16'h0, 16'h0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            freeze = vecs[i].frz;
            branch_taken = vecs[i].br;
            branch_address = vecs[i].ba;
            imem_data = vecs[i].im;
            @(negedge clk);
            check_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].pc4,
                      vecs[i].ins, vecs[i].v, vecs[i].sc, vecs[i].fc);
        end

        // Asynchronous reset between edges must clear without a clock.
        freeze = 1'b0;
        branch_taken = 1'b0;
        #2 rst = 1'b1;
        #1 check_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        rst = 1'b0;

        rst2 = 1'b0;
        freeze2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("sat_stall%0d", i), {30'b0, stall_count2},
                  (i < 3) ? 32'(i + 1) : 32'd3);
            check($sformatf("sat_pc%0d", i), imem_addr2, 32'h100);
        end
        check("sat_flush", {30'b0, flush_count2}, 32'd0);

        #2 rst2 = 1'b1;
        #1;
        check("rst2_pc", imem_addr2, 32'h100);
        check("rst2_stall", {30'b0, stall_count2}, 32'd0);
        check("rst2_pc4", id_pc_plus4_2, 32'h0);
        check("rst2_instr", id_instruction2, 32'h0);
        check("rst2_valid", {31'b0, id_valid2}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/if_stage_unit.md
Name: if_stage_unit

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS pipeline.
- Sits directly upstream of the ID stage and the hazard-detection logic, and consumes its `hazard_detected` as `freeze`.
- Holds the PC, presents the fetch address to instruction memory, and captures {pc_plus4, instruction, valid} for ID.
- Applies stall and branch-flush, and keeps saturating stall/flush event counters for debug.

Parameters:
- ADDR_W, 32, PC and address width in bits.
- PC_RESET, 0, PC value loaded on reset (word-aligned).
- CNT_W, 16, width of the stall and flush event counters.

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- freeze  in  1  stall request from hazard detection (hazard_detected); hold PC and IF/ID.
- branch_taken  in  1  ID-stage branch/jump resolved taken this cycle.
- branch_address  in  ADDR_W  branch target from ID.
- imem_addr  out  ADDR_W  fetch address to instruction memory (= PC).
- imem_data  in  32  instruction word returned combinationally for imem_addr.
- id_pc_plus4  out  ADDR_W  registered PC+4 of the instruction in ID.
- id_instruction  out  32  registered instruction for ID; 0 (NOP) when invalid.
- id_valid  out  1  registered; 1 when id_instruction is a real fetched instruction.
- stall_count  out  CNT_W  number of frozen cycles, saturating.
- flush_count  out  CNT_W  number of branch flushes, saturating.

Behaviour:
- Reset (async, rst=1): PC=PC_RESET, id_pc_plus4=0, id_instruction=0, id_valid=0, stall_count=0, flush_count=0.
  - Reset asserted mid-operation discards all in-flight state immediately, without waiting for clk.
- imem_addr = PC, combinational from the register. Fetch latency is one cycle: the word appears in IF/ID on the next edge.
- Priority on each rising edge (rst=0): freeze > branch_taken > normal.
- FREEZE (freeze=1):
  - PC, id_pc_plus4, id_instruction and id_valid all hold.
  - branch_taken is ignored, because the stalled ID instruction's operands are not valid.
  - stall_count increments unless it is all ones.
- FLUSH (freeze=0, branch_taken=1):
  - PC <= {branch_address[ADDR_W-1:2], 2'b00}; the low bits are forced to 0.
  - id_instruction <= 0, id_valid <= 0, id_pc_plus4 <= 0. The wrong-path fetch is squashed into a bubble.
  - flush_count increments unless it is all ones.
- NORMAL (freeze=0, branch_taken=0):
  - PC <= PC+4, computed modulo 2^ADDR_W; 0xFFFFFFFC wraps to 0x00000000 with no flag.
  - id_pc_plus4 <= PC+4 (same wrap), id_instruction <= imem_data, id_valid <= 1.
- Counters:
  - unsigned, saturate at 2^CNT_W-1 and never wrap;
  - cleared only by rst.
- No internal FSM beyond the three per-cycle modes; the modes are mutually exclusive and fully decoded by the priority rule above.
- X on branch_address while branch_taken=0 must not propagate into any register.

Decomposition:
- Shared package (pipeline pkg):
  - NOP_INSTR = 32'h0000_0000;
  - an IF/ID bundle typedef {pc_plus4, instruction, valid}, reused by the ID stage;
  - ADDR_W default.
- One natural sub-module: sat_counter (width parameter, inc, rst, count), instantiated twice for the stall and flush counters.
- PC and IF/ID register stay in the top block.

Test Plan:
- Reset then 3 free cycles with imem_data=0x20010005, 0x20020007, 0x00221820 → PC sequence 0x0, 0x4, 0x8, 0xC.
  - After the first edge: id_instruction=0x20010005, id_pc_plus4=0x4, id_valid=1.
- freeze=1 for 2 cycles at PC=0x8 → PC stays 0x8, IF/ID unchanged, stall_count=2.
  - On release the next edge loads imem_data at 0x8 and PC becomes 0xC.
- branch_taken=1, branch_address=0x43 at PC=0x10 → PC=0x40, id_valid=0, id_instruction=0, flush_count=1.
  - The next edge fetches from 0x40.
- freeze=1 and branch_taken=1 together at PC=0x20 → PC stays 0x20, flush_count unchanged, stall_count+1.
- PC forced to 0xFFFFFFFC via branch, then a free cycle → PC=0x0, id_pc_plus4=0x0, id_valid=1.
- CNT_W=2 with 5 consecutive freeze cycles → stall_count=3 and holds.
  - Assert rst asynchronously between edges → all outputs zero immediately, PC=PC_RESET.
